// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: LANES S-box lanes time-multiplexed over the 16 state bytes.
// Define SUB_BYTES_SEQ_INV_SBOX_EN to build the inverse S-box and honour i_in_inv.
//
// state  | meaning
// S_IDLE | waiting for a state, i_in_ready high
// S_BUSY | substituting LANES bytes per cycle, low byte first
// S_DONE | result held on o_out_state until the output handshake
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_state,
  input  logic         i_in_inv,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_state,
  output logic         o_busy
);

  localparam int CYCLES = 16 / LANES;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [127:0]       r_work;
  logic               r_mode;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [127:0]       r_out_state;
  logic               r_busy;

  logic [7:0]         w_lane_in  [LANES];
  logic [7:0]         w_lane_out [LANES];
  logic [127:0]       w_work_nxt;

  // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    logic [7:0] x;
    x = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction
`endif

  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      logic [6:0] w_bit_lo;
      logic [7:0] w_fwd;
      assign w_bit_lo    = {4'(int'(r_cnt) * LANES + l), 3'b000};
      assign w_lane_in[l] = r_work[w_bit_lo +: 8];
      assign w_fwd       = sbox_fwd(w_lane_in[l]);
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
      logic [7:0] w_inv;
      assign w_inv         = sbox_inv(w_lane_in[l]);
      assign w_lane_out[l] = r_mode ? w_inv : w_fwd;
`else
      assign w_lane_out[l] = w_fwd;
`endif
    end
  endgenerate

`ifndef SUB_BYTES_SEQ_INV_SBOX_EN
  logic w_unused_mode;
  assign w_unused_mode = i_in_inv ^ r_mode;
`endif

  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < LANES; k++) begin
      w_work_nxt[{4'(int'(r_cnt) * LANES + k), 3'b000} +: 8] = w_lane_out[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_state <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_work     <= i_in_state;
`ifdef SUB_BYTES_SEQ_INV_SBOX_EN
            r_mode     <= i_in_inv;
`else
            r_mode     <= 1'b0;
`endif
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_work <= w_work_nxt;
          if (r_cnt == CNT_LAST) begin
            r_cnt       <= '0;
            r_out_state <= w_work_nxt;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_state = r_out_state;
  assign o_busy      = r_busy;

endmodule
